// File: rtl/alu_op_decoder.sv
// -----------------------------------------------------------------------------
// alu_op_decoder
//   Main control decoder for a MIPS-style single-issue datapath. The opcode
//   (instruction[31:26]) and, for R-type only, the function field
//   (instruction[5:0]) are decoded combinationally into ALU and datapath
//   controls. Every control is registered, so a decode issued on one rising
//   edge is visible on the outputs right after that edge, once per cycle.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset, clears every output
//   op           instruction[31:26]
//   funct        instruction[5:0], looked at only when op == 0x00
//   alu_op       ALU operation code
//   reg_write    write the register file
//   reg_dst      destination is rd (else rt)
//   alu_src      ALU B operand is the immediate
//   zero_extend  immediate is zero-extended (else sign-extended)
//   mem_read     load
//   mem_write    store
//   mem_to_reg   write-back data comes from memory
//   branch       conditional branch
//   bne_or_beq   1 = bne, 0 = beq (meaningful only with branch)
//   jump         j or jal
//   is_jal       jal, link to $31
//   is_jr        jr
//   is_syscall   syscall
//   is_shamt     ALU A operand is the shamt field
//   is_cop0      coprocessor-0 opcode (0x10)
//   read_rs      instruction reads rs
//   read_rt      instruction reads rt
// -----------------------------------------------------------------------------
module alu_op_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src,
  output logic       zero_extend,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       branch,
  output logic       bne_or_beq,
  output logic       jump,
  output logic       is_jal,
  output logic       is_jr,
  output logic       is_syscall,
  output logic       is_shamt,
  output logic       is_cop0,
  output logic       read_rs,
  output logic       read_rt
);

  typedef enum logic [3:0] {
    ALU_SLL  = 4'b0000,
    ALU_SRA  = 4'b0001,
    ALU_SRL  = 4'b0010,
    ALU_ADD  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_XOR  = 4'b1001,
    ALU_NOR  = 4'b1010,
    ALU_SLT  = 4'b1011,
    ALU_SLTU = 4'b1100
  } aluOpT;

  typedef struct packed {
    aluOpT aluOp;
    logic  regWrite;
    logic  regDst;
    logic  aluSrc;
    logic  zeroExtend;
    logic  memRead;
    logic  memWrite;
    logic  memToReg;
    logic  branch;
    logic  bneOrBeq;
    logic  jump;
    logic  isJal;
    logic  isJr;
    logic  isSyscall;
    logic  isShamt;
    logic  isCop0;
    logic  readRs;
    logic  readRt;
  } ctrlT;

  ctrlT dec;
  ctrlT ctrlQ;

  // Shared controls for the twelve R-type ALU instructions; the shifts take
  // their A operand from shamt instead of rs.
  function automatic ctrlT rAlu(input aluOpT code, input logic isShift);
    ctrlT c;
    c          = '0;
    c.aluOp    = code;
    c.regWrite = 1'b1;
    c.regDst   = 1'b1;
    c.readRt   = 1'b1;
    c.readRs   = ~isShift;
    c.isShamt  = isShift;
    return c;
  endfunction

  // Shared controls for the immediate ALU instructions.
  function automatic ctrlT iAlu(input aluOpT code, input logic zext);
    ctrlT c;
    c            = '0;
    c.aluOp      = code;
    c.regWrite   = 1'b1;
    c.aluSrc     = 1'b1;
    c.readRs     = 1'b1;
    c.zeroExtend = zext;
    return c;
  endfunction

  // NOTE: dec gets an all-zero default before the case so every path assigns
  // it; without it an unlisted opcode would hold the old value and infer a latch.
  // The all-zero default is also the decode for every undefined op/funct.
  always_comb begin
    dec = '0;
    case (op)
      6'h00: begin
        // funct is only inspected here, so X on funct cannot leak into
        // the decode of any other opcode.
        case (funct)
          6'h00: dec = rAlu(ALU_SLL,  1'b1);
          6'h02: dec = rAlu(ALU_SRL,  1'b1);
          6'h03: dec = rAlu(ALU_SRA,  1'b1);
          6'h20: dec = rAlu(ALU_ADD,  1'b0);
          6'h21: dec = rAlu(ALU_ADD,  1'b0);
          6'h22: dec = rAlu(ALU_SUB,  1'b0);
          6'h24: dec = rAlu(ALU_AND,  1'b0);
          6'h25: dec = rAlu(ALU_OR,   1'b0);
          6'h26: dec = rAlu(ALU_XOR,  1'b0);
          6'h27: dec = rAlu(ALU_NOR,  1'b0);
          6'h2A: dec = rAlu(ALU_SLT,  1'b0);
          6'h2B: dec = rAlu(ALU_SLTU, 1'b0);
          6'h08: begin
            dec.isJr   = 1'b1;
            dec.readRs = 1'b1;
          end
          6'h0C: dec.isSyscall = 1'b1;
          default: dec = '0;
        endcase
      end
      6'h08, 6'h09: dec = iAlu(ALU_ADD, 1'b0);
      6'h0A:        dec = iAlu(ALU_SLT, 1'b0);
      6'h0C:        dec = iAlu(ALU_AND, 1'b1);
      6'h0D:        dec = iAlu(ALU_OR,  1'b1);
      6'h0E:        dec = iAlu(ALU_XOR, 1'b1);
      6'h23: begin
        dec.aluOp    = ALU_ADD;
        dec.regWrite = 1'b1;
        dec.aluSrc   = 1'b1;
        dec.memRead  = 1'b1;
        dec.memToReg = 1'b1;
        dec.readRs   = 1'b1;
      end
      6'h2B: begin
        dec.aluOp    = ALU_ADD;
        dec.aluSrc   = 1'b1;
        dec.memWrite = 1'b1;
        dec.readRs   = 1'b1;
        dec.readRt   = 1'b1;
      end
      6'h04, 6'h05: begin
        dec.aluOp    = ALU_SUB;
        dec.branch   = 1'b1;
        dec.bneOrBeq = op[0];
        dec.readRs   = 1'b1;
        dec.readRt   = 1'b1;
      end
      6'h02: dec.jump = 1'b1;
      6'h03: begin
        dec.jump     = 1'b1;
        dec.isJal    = 1'b1;
        dec.regWrite = 1'b1;
      end
      6'h10: dec.isCop0 = 1'b1;
      default: dec = '0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge decode, independent of statement order.
  // NOTE: the output register is reset (it is control, not a data array), so a
  // reset asserted mid-stream discards the pending decode at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrlQ <= '0;
    end else begin
      ctrlQ <= dec;
    end
  end

  assign alu_op      = ctrlQ.aluOp;
  assign reg_write   = ctrlQ.regWrite;
  assign reg_dst     = ctrlQ.regDst;
  assign alu_src     = ctrlQ.aluSrc;
  assign zero_extend = ctrlQ.zeroExtend;
  assign mem_read    = ctrlQ.memRead;
  assign mem_write   = ctrlQ.memWrite;
  assign mem_to_reg  = ctrlQ.memToReg;
  assign branch      = ctrlQ.branch;
  assign bne_or_beq  = ctrlQ.bneOrBeq;
  assign jump        = ctrlQ.jump;
  assign is_jal      = ctrlQ.isJal;
  assign is_jr       = ctrlQ.isJr;
  assign is_syscall  = ctrlQ.isSyscall;
  assign is_shamt    = ctrlQ.isShamt;
  assign is_cop0     = ctrlQ.isCop0;
  assign read_rs     = ctrlQ.readRs;
  assign read_rt     = ctrlQ.readRt;

endmodule

// File: tb/tb_alu_op_decoder.sv
// -----------------------------------------------------------------------------
// tb_alu_op_decoder
//   Self-checking bench for alu_op_decoder. Expected controls come from a rule
//   table written from the instruction set description: each rule names an
//   opcode, an optional function code and the set of controls that go high.
//   Anything not matched by a rule decodes to all zeros.
// -----------------------------------------------------------------------------
module tb_alu_op_decoder;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic [3:0] alu_op;
  logic       reg_write, reg_dst, alu_src, zero_extend, mem_read, mem_write;
  logic       mem_to_reg, branch, bne_or_beq, jump, is_jal, is_jr, is_syscall;
  logic       is_shamt, is_cop0, read_rs, read_rt;

  int nCompared;
  int nMismatched;

  alu_op_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .alu_src    (alu_src),
    .zero_extend(zero_extend),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .branch     (branch),
    .bne_or_beq (bne_or_beq),
    .jump       (jump),
    .is_jal     (is_jal),
    .is_jr      (is_jr),
    .is_syscall (is_syscall),
    .is_shamt   (is_shamt),
    .is_cop0    (is_cop0),
    .read_rs    (read_rs),
    .read_rt    (read_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed/expected vector layout: {alu_op[3:0], 17 flag bits}.
  localparam logic [16:0] RW   = 17'h10000; // reg_write
  localparam logic [16:0] RD   = 17'h08000; // reg_dst
  localparam logic [16:0] AS   = 17'h04000; // alu_src
  localparam logic [16:0] ZX   = 17'h02000; // zero_extend
  localparam logic [16:0] MR   = 17'h01000; // mem_read
  localparam logic [16:0] MW   = 17'h00800; // mem_write
  localparam logic [16:0] M2R  = 17'h00400; // mem_to_reg
  localparam logic [16:0] BR   = 17'h00200; // branch
  localparam logic [16:0] BNE  = 17'h00100; // bne_or_beq
  localparam logic [16:0] JMP  = 17'h00080; // jump
  localparam logic [16:0] JAL  = 17'h00040; // is_jal
  localparam logic [16:0] JR   = 17'h00020; // is_jr
  localparam logic [16:0] SYS  = 17'h00010; // is_syscall
  localparam logic [16:0] SHA  = 17'h00008; // is_shamt
  localparam logic [16:0] CP0  = 17'h00004; // is_cop0
  localparam logic [16:0] RS   = 17'h00002; // read_rs
  localparam logic [16:0] RT   = 17'h00001; // read_rt

  typedef struct {
    logic [5:0]  op;
    int          funct;   // -1 = any funct
    logic [20:0] exp;
  } ruleT;

  ruleT rules[$];

  function automatic logic [20:0] observed();
    return {alu_op, reg_write, reg_dst, alu_src, zero_extend, mem_read,
            mem_write, mem_to_reg, branch, bne_or_beq, jump, is_jal, is_jr,
            is_syscall, is_shamt, is_cop0, read_rs, read_rt};
  endfunction

  task automatic addRule(input logic [5:0] o, input int f, input logic [3:0] a,
                         input logic [16:0] flags);
    ruleT r;
    r.op    = o;
    r.funct = f;
    r.exp   = {a, flags};
    rules.push_back(r);
  endtask

  task automatic buildRules();
    // R-type ALU instructions: {funct, alu code, is a shift}
    int          rF[12] = '{'h00, 'h02, 'h03, 'h20, 'h21, 'h22, 'h24, 'h25,
                            'h26, 'h27, 'h2A, 'h2B};
    logic [3:0]  rA[12] = '{4'd0, 4'd2, 4'd1, 4'd5, 4'd5, 4'd6, 4'd7, 4'd8,
                            4'd9, 4'd10, 4'd11, 4'd12};
    for (int i = 0; i < 12; i++)
      addRule(6'h00, rF[i], rA[i], RW | RD | RT | ((i < 3) ? SHA : RS));
    addRule(6'h00, 'h08, 4'd0, JR | RS);
    addRule(6'h00, 'h0C, 4'd0, SYS);
    addRule(6'h08, -1, 4'd5,  RW | AS | RS);
    addRule(6'h09, -1, 4'd5,  RW | AS | RS);
    addRule(6'h0A, -1, 4'd11, RW | AS | RS);
    addRule(6'h0C, -1, 4'd7,  RW | AS | RS | ZX);
    addRule(6'h0D, -1, 4'd8,  RW | AS | RS | ZX);
    addRule(6'h0E, -1, 4'd9,  RW | AS | RS | ZX);
    addRule(6'h23, -1, 4'd5,  RW | AS | MR | M2R | RS);
    addRule(6'h2B, -1, 4'd5,  AS | MW | RS | RT);
    addRule(6'h04, -1, 4'd6,  BR | RS | RT);
    addRule(6'h05, -1, 4'd6,  BR | BNE | RS | RT);
    addRule(6'h02, -1, 4'd0,  JMP);
    addRule(6'h03, -1, 4'd0,  JMP | JAL | RW);
    addRule(6'h10, -1, 4'd0,  CP0);
  endtask

  function automatic logic [20:0] refModel(input logic [5:0] o, input logic [5:0] f);
    foreach (rules[i]) begin
      if (rules[i].op == o && (rules[i].funct < 0 || f === 6'(rules[i].funct)))
        return rules[i].exp;
    end
    return '0;
  endfunction

  // Apply one instruction on the falling edge and return after the next
  // rising edge has registered it.
  task automatic issue(input logic [5:0] o, input logic [5:0] f);
    @(negedge clk);
    op    = o;
    funct = f;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    rst_n = 1'b0;
    op    = 6'h23;
    funct = 6'h00;
    #1;
    got = observed();
    nCompared++;
    if (got !== 21'h0) begin
      nMismatched++;
      $display("FAIL reset_initial: got %h, want %h", got, 21'h0);
    end
    // Clock edges under reset must not load the decode.
    repeat (2) @(posedge clk);
    #1;
    got = observed();
    nCompared++;
    if (got !== 21'h0) begin
      nMismatched++;
      $display("FAIL reset_held_over_edges: got %h, want %h", got, 21'h0);
    end
    // First edge after release decodes what is on the inputs (lw).
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got = observed();
    nCompared++;
    if (got !== refModel(6'h23, 6'h00)) begin
      nMismatched++;
      $display("FAIL reset_first_edge: got %h, want %h", got, refModel(6'h23, 6'h00));
    end
  endtask

  task automatic test_add();
    logic [20:0] want;
    logic [20:0] got;
    issue(6'h00, 6'h20);
    got  = observed();
    want = {4'b0101, RW | RD | RS | RT};
    nCompared++;
    if (got !== want || got !== refModel(6'h00, 6'h20)) begin
      nMismatched++;
      $display("FAIL add_rtype: got %h, want %h", got, want);
    end
  endtask

  task automatic test_rtype_all();
    int          fList[14] = '{'h00, 'h02, 'h03, 'h20, 'h21, 'h22, 'h24, 'h25,
                              'h26, 'h27, 'h2A, 'h2B, 'h08, 'h0C};
    logic [20:0] got;
    for (int i = 0; i < 14; i++) begin
      issue(6'h00, 6'(fList[i]));
      got = observed();
      nCompared++;
      if (got !== refModel(6'h00, 6'(fList[i]))) begin
        nMismatched++;
        $display("FAIL rtype_funct_%h: got %h, want %h", fList[i], got,
                 refModel(6'h00, 6'(fList[i])));
      end
    end
  endtask

  task automatic test_jr_syscall();
    logic [20:0] got;
    issue(6'h00, 6'h08);
    got = observed();
    nCompared++;
    if (got !== {4'b0000, JR | RS}) begin
      nMismatched++;
      $display("FAIL jr: got %h, want %h", got, {4'b0000, JR | RS});
    end
    issue(6'h00, 6'h0C);
    got = observed();
    nCompared++;
    if (got !== {4'b0000, SYS} || reg_write !== 1'b0) begin
      nMismatched++;
      $display("FAIL syscall: got %h, want %h", got, {4'b0000, SYS});
    end
  endtask

  task automatic test_mem_funct_x();
    logic [20:0] got;
    issue(6'h23, 6'bxxxxxx);
    got = observed();
    nCompared++;
    if (got !== {4'b0101, RW | AS | MR | M2R | RS}) begin
      nMismatched++;
      $display("FAIL lw_funct_x: got %h, want %h", got, {4'b0101, RW | AS | MR | M2R | RS});
    end
    issue(6'h2B, 6'bxxxxxx);
    got = observed();
    nCompared++;
    if (got !== {4'b0101, AS | MW | RS | RT}) begin
      nMismatched++;
      $display("FAIL sw_funct_x: got %h, want %h", got, {4'b0101, AS | MW | RS | RT});
    end
  endtask

  task automatic test_branch();
    logic [20:0] got;
    issue(6'h04, 6'h15);
    got = observed();
    nCompared++;
    if (got !== {4'b0110, BR | RS | RT}) begin
      nMismatched++;
      $display("FAIL beq: got %h, want %h", got, {4'b0110, BR | RS | RT});
    end
    issue(6'h05, 6'h2A);
    got = observed();
    nCompared++;
    if (got !== {4'b0110, BR | BNE | RS | RT}) begin
      nMismatched++;
      $display("FAIL bne: got %h, want %h", got, {4'b0110, BR | BNE | RS | RT});
    end
  endtask

  task automatic test_jal_cop0();
    logic [20:0] got;
    issue(6'h03, 6'h00);
    got = observed();
    nCompared++;
    if (got !== {4'b0000, JMP | JAL | RW}) begin
      nMismatched++;
      $display("FAIL jal: got %h, want %h", got, {4'b0000, JMP | JAL | RW});
    end
    issue(6'h10, 6'h18);
    got = observed();
    nCompared++;
    if (got !== {4'b0000, CP0}) begin
      nMismatched++;
      $display("FAIL cop0: got %h, want %h", got, {4'b0000, CP0});
    end
  endtask

  task automatic test_immediates();
    logic [5:0]  oList[7] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h02};
    logic [20:0] got;
    for (int i = 0; i < 7; i++) begin
      issue(oList[i], 6'($urandom_range(0, 63)));
      got = observed();
      nCompared++;
      if (got !== refModel(oList[i], funct)) begin
        nMismatched++;
        $display("FAIL op_%h: got %h, want %h", oList[i], got, refModel(oList[i], funct));
      end
    end
  endtask

  task automatic test_async_reset();
    logic [20:0] got;
    issue(6'h0D, 6'h00);
    got = observed();
    nCompared++;
    if (got !== {4'b1000, RW | AS | RS | ZX}) begin
      nMismatched++;
      $display("FAIL ori_before_reset: got %h, want %h", got, {4'b1000, RW | AS | RS | ZX});
    end
    // Assert reset between edges and look before any further clock edge.
    #2;
    op    = 6'h3F;
    rst_n = 1'b0;
    #1;
    got = observed();
    nCompared++;
    if (got !== 21'h0) begin
      nMismatched++;
      $display("FAIL async_reset_clear: got %h, want %h", got, 21'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got = observed();
    nCompared++;
    if (got !== 21'h0) begin
      nMismatched++;
      $display("FAIL unknown_op_3f: got %h, want %h", got, 21'h0);
    end
  endtask

  task automatic test_undefined();
    logic [5:0]  uFunct[4] = '{6'h01, 6'h09, 6'h3F, 6'h2C};
    logic [20:0] got;
    for (int i = 0; i < 4; i++) begin
      issue(6'h00, uFunct[i]);
      got = observed();
      nCompared++;
      if (got !== 21'h0) begin
        nMismatched++;
        $display("FAIL undef_funct_%h: got %h, want %h", uFunct[i], got, 21'h0);
      end
    end
  endtask

  // Random back-to-back decodes, new instruction every cycle.
  task automatic test_back_to_back();
    logic [5:0]  defOps[15] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C,
                               6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0]  o;
    logic [5:0]  f;
    logic [20:0] got;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) != 0) o = defOps[$urandom_range(0, 14)];
      else                           o = 6'($urandom_range(0, 63));
      f = 6'($urandom_range(0, 63));
      issue(o, f);
      got = observed();
      nCompared++;
      if (got !== refModel(o, f)) begin
        nMismatched++;
        $display("FAIL random_op_%h_funct_%h: got %h, want %h", o, f, got, refModel(o, f));
      end
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    buildRules();
    test_reset();
    test_add();
    test_rtype_all();
    test_jr_syscall();
    test_mem_funct_x();
    test_branch();
    test_jal_cop0();
    test_immediates();
    test_async_reset();
    test_undefined();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/alu_op_decoder.md
ALU_OP_DECODER -- requirements
Module: alu_op_decoder

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port list, in this order:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  6  instruction[31:26]
- funct  in  6  instruction[5:0]
- alu_op  out  4  ALU operation code
- reg_write  out  1  write to register file
- reg_dst  out  1  destination is rd (else rt)
- alu_src  out  1  ALU B operand is the immediate
- zero_extend  out  1  immediate is zero-extended (else sign-extended)
- mem_read  out  1  load
- mem_write  out  1  store
- mem_to_reg  out  1  write-back data comes from memory
- branch  out  1  conditional branch
- bne_or_beq  out  1  1 = bne, 0 = beq (valid only with branch)
- jump  out  1  j or jal
- is_jal  out  1  jal (link to $31)
- is_jr  out  1  jr
- is_syscall  out  1  syscall
- is_shamt  out  1  ALU A operand is the shamt field
- is_cop0  out  1  op = 0x10
- read_rs  out  1  instruction reads rs
- read_rt  out  1  instruction reads rt

Function
REQ-004 Decode SHALL be purely combinational from op/funct; every output SHALL be registered on the rising clk edge (latency 1 cycle, new decode every cycle, no handshake).
REQ-005 funct SHALL be ignored (including X values) when op != 0x00.
REQ-006 alu_op encoding: 0000 SLL, 0001 SRA, 0010 SRL, 0101 ADD, 0110 SUB, 0111 AND, 1000 OR, 1001 XOR, 1010 NOR, 1011 SLT, 1100 SLTU.
REQ-007 R-type (op 0x00) by funct: 0x00 sll, 0x02 srl, 0x03 sra, 0x20 add, 0x21 addu, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x2B sltu -> alu_op per REQ-006 (add/addu ADD); reg_write=1, reg_dst=1, read_rt=1; read_rs=1 except sll/srl/sra, which set is_shamt=1.
REQ-008 R-type funct 0x08 (jr): is_jr=1, read_rs=1, alu_op 0000, all else 0.
REQ-009 R-type funct 0x0C (syscall): is_syscall=1, alu_op 0000, all else 0.
REQ-010 I-type ALU: addi 0x08, addiu 0x09 -> ADD; slti 0x0A -> SLT; andi 0x0C -> AND; ori 0x0D -> OR; xori 0x0E -> XOR; each: reg_write=1, alu_src=1, read_rs=1; zero_extend=1 only for andi/ori/xori.
REQ-011 lw 0x23: ADD, reg_write, alu_src, mem_read, mem_to_reg, read_rs = 1.
REQ-012 sw 0x2B: ADD, alu_src, mem_write, read_rs, read_rt = 1.
REQ-013 beq 0x04 / bne 0x05: SUB, branch, read_rs, read_rt = 1; bne_or_beq=1 for bne only.
REQ-014 j 0x02: jump=1. jal 0x03: jump=1, is_jal=1, reg_write=1. Both: alu_op 0000.
REQ-015 op 0x10: is_cop0=1, all else 0, any funct.
REQ-016 Any undefined op, or undefined funct with op 0x00, SHALL yield all outputs 0 (alu_op 0000).
REQ-017 Any output not set to 1 by REQ-007..REQ-015 SHALL be 0.

Reset
REQ-018 rst_n low SHALL immediately (asynchronously) force all outputs to 0, independent of clk.
REQ-019 After rst_n deasserts, outputs SHALL reflect the op/funct sampled at the first rising clk edge; reset asserted mid-stream discards the pending decode.

Verification
REQ-020 op 0x00, funct 0x20 -> next edge: alu_op 0101, reg_write=1, reg_dst=1, read_rs=1, read_rt=1, others 0.
REQ-021 op 0x00, funct 0x08 then 0x0C -> is_jr=1, read_rs=1; then is_syscall=1, reg_write=0.
REQ-022 op 0x23 then 0x2B (funct=X) -> lw: mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1; sw: mem_write=1, read_rt=1, reg_write=0; alu_op 0101 both.
REQ-023 op 0x04 then 0x05 -> branch=1, alu_op 0110, bne_or_beq 0 then 1.
REQ-024 op 0x03 then 0x10 (funct 0x18) -> jump=1, is_jal=1, reg_write=1; then is_cop0=1 only.
REQ-025 op 0x0D decoded, then rst_n low between edges -> all outputs 0 immediately; unknown op 0x3F after release -> all 0.
